lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Data-memory responder for the core's load/store control outputs: RAM_write_en, RAM_read_en, RAM_ram_type and RAM_sign.
- Converts each byte, halfword or word request into word-addressed accesses to a synchronous 32-bit data RAM with per-byte write enables.
- Splits misaligned accesses into two word accesses and returns load data sign- or zero-extended.
- Holds the pipeline via lsu_busy until the access completes.

Parameters:
- ADDR_W, 10: word-address width of the data RAM (RAM depth = 2^ADDR_W words).
- MISALIGN_EN, 1: 1 = split misaligned accesses into two word accesses; 0 = raise lsu_err and perform no access.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_read_en  in  1  load request (from RAM_read_en).
- req_write_en  in  1  store request (from RAM_write_en).
- req_type  in  4  access size: BYTE=4'b0001, HALFWORD=4'b0011, FULLWORD=4'b1111 (GLOBALS encodings).
- req_sign  in  1  1 = sign-extend load, 0 = zero-extend.
- req_addr  in  32  byte address (ALU output).
- req_wdata  in  32  store data (rs2); low byte/halfword used for narrow stores.
- lsu_busy  out  1  registered; 1 = port occupied, pipeline must hold the request stable.
- load_data  out  32  extended load result.
- load_valid  out  1  one-cycle pulse when load_data is valid.
- lsu_err  out  1  one-cycle pulse on a rejected request.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write (with mem_en).
- mem_be  out  4  byte enables; bit i = byte lane i, bits[8i+7:8i].
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  RAM read data, valid the cycle after the mem_en read cycle.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers cleared.
- States: IDLE, ACC2, RD_W1, RD_W2.
  - IDLE: a request is accepted at a rising edge only in IDLE.
  - ACC2: second word of a misaligned access.
  - RD_W1 / RD_W2: waiting for the first / second read word.
- Decode on accept:
  - o = req_addr[1:0]; wa = req_addr[ADDR_W+1:2].
  - Misaligned = halfword with o=3, or word with o!=0. Bytes are never misaligned.
- Rejected requests (lsu_err=1 next cycle, no mem_en, stay IDLE):
  - req_read_en and req_write_en both high;
  - req_type not one of the three legal encodings;
  - misaligned with MISALIGN_EN=0.
- Registered mem_* outputs, cycle after accept = first access cycle:
  - addr = wa, be = (size mask << o) truncated to 4 bits.
  - wdata = req_wdata << 8o.
- Second access (misaligned only):
  - addr = wa+1 mod 2^ADDR_W (wraps at top of RAM).
  - be = size mask >> (4-o); wdata = req_wdata >> 8(4-o).
- Aligned store:
  - Accept at edge E0; write cycle E0..E1.
  - IDLE at E1; lsu_busy high for 1 cycle.
- Misaligned store: writes in E0..E1 and E1..E2; busy 2 cycles.
- Aligned load:
  - Read cycle E0..E1; mem_rdata captured at E2.
  - load_valid=1 in cycle E2..E3; busy 2 cycles.
- Misaligned load:
  - word0 read E0..E1, word1 read E1..E2.
  - word0 captured at E2, word1 at E3; load_valid in cycle E3..E4; busy 3 cycles.
- Load extraction:
  - x = {word1, word0} >> 8o.
  - Byte: x[7:0] extended. Halfword: x[15:0] extended. Word: x[31:0], req_sign ignored.
  - Extension is sign when the latched req_sign=1, zero otherwise.
- Request fields (type, sign, o) are latched at accept; the input may change while busy without effect.
- load_data holds its value until the next load completes.
- mem_en=0 whenever the port is not accessing; mem_we=0 on reads.
- Requests presented while lsu_busy=1 are ignored; the pipeline must stall.
- Reset mid-operation returns to IDLE at that edge with mem_en=0 and no load_valid. A partially written misaligned store stays partially written.

Test Plan:
- Store byte addr 0x13, wdata 0xAB -> mem_addr=4, be=1000, wdata=0xAB000000, one busy cycle; load byte signed 0x13 -> load_data=0xFFFFFFAB two cycles after accept.
- Load halfword unsigned addr 0x22 with RAM[8]=0x8001_7F00 -> be not driven (read), load_data=0x00008001, load_valid one cycle.
- Misaligned word store 0x11223344 to addr 0x07 -> write addr 1 be=1000 wdata=0x44000000, then addr 2 be=0111 wdata=0x00112233; read back word at 0x07 -> 0x11223344 after three busy cycles.
- Misaligned access with MISALIGN_EN=0, and req_type=4'b0101 -> lsu_err pulse, mem_en never high, lsu_busy stays 0.
- Word store at top word address (0x3FF, ADDR_W=10) with o=2 -> second access at mem_addr=0 (wrap).
- rst asserted in the cycle after a misaligned load accept -> outputs 0 next edge, no load_valid, a new request accepted the following cycle.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store responder: turns byte/halfword/word requests into word accesses on a
// synchronous byte-enabled data RAM, splitting misaligned ones across two words.
module lsu_mem_port #(
  parameter int ADDR_W      = 10,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read_en,
  input  logic              req_write_en,
  input  logic [3:0]        req_type,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              lsu_busy,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              lsu_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] T_BYTE = 4'b0001;
  localparam logic [3:0] T_HALF = 4'b0011;
  localparam logic [3:0] T_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, ACC2, RD_W1, RD_W2} state_t;

  state_t            r_state;
  logic              r_busy, r_load_valid, r_err;
  logic [31:0]       r_load_data;
  logic              r_mem_en, r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_type;
  logic              r_sign, r_mis, r_is_load, r_rvalid;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_addr2;
  logic [3:0]        r_be2;
  logic [31:0]       r_wdata2, r_word0;

  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_wa;
  logic              w_legal, w_mis, w_req, w_reject, w_idle, w_accept, w_err, w_finish;
  logic [7:0]        w_be_ext;
  logic [63:0]       w_wd_ext;
  logic [31:0]       w_lw0, w_x, w_ext;
  logic [23:0]       w_lw1;
  logic              w_unused_addr_hi;

  assign w_off    = req_addr[1:0];
  assign w_wa     = req_addr[ADDR_W+1:2];
  assign w_legal  = (req_type == T_BYTE) || (req_type == T_HALF) || (req_type == T_WORD);
  assign w_mis    = ((req_type == T_HALF) && (w_off == 2'd3)) ||
                    ((req_type == T_WORD) && (w_off != 2'd0));
  assign w_req    = req_read_en | req_write_en;
  assign w_reject = (req_read_en & req_write_en) | ~w_legal | (w_mis & ~MISALIGN_EN);
  assign w_idle   = (r_state == IDLE) && !r_busy;
  assign w_accept = w_idle && w_req && !w_reject;
  assign w_err    = w_idle && w_req && w_reject;
  assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Upper halves of the shifted mask/data are exactly the second-word lanes.
  assign w_be_ext = {4'b0000, req_type} << w_off;
  assign w_wd_ext = {32'h0, req_wdata} << {w_off, 3'b000};

  assign w_finish = r_rvalid && (((r_state == RD_W1) && !r_mis) || (r_state == RD_W2));
  assign w_lw0    = (r_state == RD_W2) ? r_word0 : mem_rdata;
  assign w_lw1    = (r_state == RD_W2) ? mem_rdata[23:0] : 24'h0;

  always_comb begin
    w_x = w_lw0;
    case (r_off)
      2'd1:    w_x = {w_lw1[7:0],  w_lw0[31:8]};
      2'd2:    w_x = {w_lw1[15:0], w_lw0[31:16]};
      2'd3:    w_x = {w_lw1[23:0], w_lw0[31:24]};
      default: w_x = w_lw0;
    endcase
    w_ext = w_x;
    case (r_type)
      T_BYTE:  w_ext = {{24{r_sign & w_x[7]}}, w_x[7:0]};
      T_HALF:  w_ext = {{16{r_sign & w_x[15]}}, w_x[15:0]};
      default: w_ext = w_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_load_valid <= 1'b0;
      r_err        <= 1'b0;
      r_load_data  <= 32'h0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'h0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'h0;
      r_type       <= 4'h0;
      r_sign       <= 1'b0;
      r_mis        <= 1'b0;
      r_is_load    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_off        <= 2'd0;
      r_addr2      <= '0;
      r_be2        <= 4'h0;
      r_wdata2     <= 32'h0;
      r_word0      <= 32'h0;
    end else begin
      r_err        <= w_err;
      r_load_valid <= 1'b0;
      // RAM data is valid in the cycle after any read strobe.
      r_rvalid     <= r_mem_en & ~r_mem_we;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'h0;
      r_mem_wdata  <= 32'h0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy      <= 1'b1;
            r_type      <= req_type;
            r_sign      <= req_sign;
            r_off       <= w_off;
            r_mis       <= w_mis;
            r_is_load   <= req_read_en;
            r_addr2     <= w_wa + 1'b1;
            r_be2       <= w_be_ext[7:4];
            r_wdata2    <= w_wd_ext[63:32];
            r_mem_en    <= 1'b1;
            r_mem_we    <= req_write_en;
            r_mem_addr  <= w_wa;
            r_mem_be    <= req_write_en ? w_be_ext[3:0] : 4'h0;
            r_mem_wdata <= req_write_en ? w_wd_ext[31:0] : 32'h0;
            if (w_mis)            r_state <= ACC2;
            else if (req_read_en) r_state <= RD_W1;
            else                  r_state <= IDLE;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ACC2: begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= ~r_is_load;
          r_mem_addr  <= r_addr2;
          r_mem_be    <= r_is_load ? 4'h0 : r_be2;
          r_mem_wdata <= r_is_load ? 32'h0 : r_wdata2;
          r_state     <= r_is_load ? RD_W1 : IDLE;
        end
        RD_W1: begin
          if (r_rvalid && r_mis) begin
            r_word0 <= mem_rdata;
            r_state <= RD_W2;
          end
        end
        default: ;
      endcase
      if (w_finish) begin
        r_load_data  <= w_ext;
        r_load_valid <= 1'b1;
        r_busy       <= 1'b0;
        r_state      <= IDLE;
      end
    end
  end

  assign lsu_busy   = r_busy;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign lsu_err    = r_err;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_be     = r_mem_be;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed requests push expected RAM accesses,
// load results and error pulses; a negedge monitor pops and compares them.
module tb_lsu_mem_port;

  localparam logic [3:0] BYTE = 4'b0001;
  localparam logic [3:0] HALF = 4'b0011;
  localparam logic [3:0] WORD = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd, wr, sgn;
  logic [3:0]  typ;
  logic [31:0] addr, wdata;
  logic        lsu_busy, load_valid, lsu_err, mem_en, mem_we;
  logic [31:0] load_data, mem_wdata, rdata;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;

  logic        d0_rd, d0_wr, d0_sgn;
  logic [3:0]  d0_typ;
  logic [31:0] d0_addr, d0_wdata;
  logic        d0_busy, d0_load_valid, d0_err, d0_mem_en, d0_mem_we;
  logic [31:0] d0_load_data, d0_mem_wdata;
  logic [3:0]  d0_mem_be;
  logic [9:0]  d0_mem_addr;

  lsu_mem_port #(.ADDR_W(10), .MISALIGN_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_read_en(rd), .req_write_en(wr), .req_type(typ),
    .req_sign(sgn), .req_addr(addr), .req_wdata(wdata), .lsu_busy(lsu_busy),
    .load_data(load_data), .load_valid(load_valid), .lsu_err(lsu_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata)
  );

  lsu_mem_port #(.ADDR_W(10), .MISALIGN_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .req_read_en(d0_rd), .req_write_en(d0_wr), .req_type(d0_typ),
    .req_sign(d0_sgn), .req_addr(d0_addr), .req_wdata(d0_wdata), .lsu_busy(d0_busy),
    .load_data(d0_load_data), .load_valid(d0_load_valid), .lsu_err(d0_err),
    .mem_en(d0_mem_en), .mem_we(d0_mem_we), .mem_be(d0_mem_be), .mem_addr(d0_mem_addr),
    .mem_wdata(d0_mem_wdata), .mem_rdata(32'h0)
  );

  // Synchronous RAM with byte enables and registered read.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rdata <= ram[mem_addr];
      end
    end
  end

  int   n_vec = 0;
  int   n_miss = 0;
  int   exp_err_n = 0;
  int   exp_err0_n = 0;
  acc_t exp_mem[$];
  logic [31:0] exp_load[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic push_mem(input logic we, input logic [9:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    acc_t e;
    e.we = we; e.addr = a; e.be = be; e.wdata = d;
    exp_mem.push_back(e);
  endtask

  // Present one request, hold it while busy (as a stalled pipeline would), check busy length.
  task automatic req(input logic r, input logic w, input logic [3:0] t, input logic s,
                     input logic [31:0] a, input logic [31:0] d, input int exp_busy,
                     input string name);
    int cnt;
    @(negedge clk);
    rd = r; wr = w; typ = t; sgn = s; addr = a; wdata = d;
    @(posedge clk); #1;
    cnt = 0;
    while (lsu_busy && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk({name, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
    rd = 1'b0; wr = 1'b0; typ = 4'h0; sgn = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  always @(negedge clk) begin
    acc_t e;
    if (mem_en) begin
      if (exp_mem.size() == 0) begin
        chk("mem_unexpected_access", 32'(mem_en), 32'h0);
      end else begin
        e = exp_mem.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) begin
          chk("mem_be", 32'(mem_be), 32'(e.be));
          chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
    end
    if (load_valid) begin
      if (exp_load.size() == 0) chk("load_unexpected", 32'(load_valid), 32'h0);
      else                      chk("load_data", load_data, exp_load.pop_front());
    end
    if (lsu_err) begin
      chk("lsu_err_expected", 32'(exp_err_n != 0), 32'h1);
      if (exp_err_n != 0) exp_err_n--;
    end
    if (d0_mem_en) chk("d0_mem_en", 32'(d0_mem_en), 32'h0);
    if (d0_err) begin
      chk("d0_err_expected", 32'(exp_err0_n != 0), 32'h1);
      if (exp_err0_n != 0) exp_err0_n--;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    rd = 0; wr = 0; sgn = 0; typ = 0; addr = 0; wdata = 0;
    d0_rd = 0; d0_wr = 0; d0_sgn = 0; d0_typ = 0; d0_addr = 0; d0_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(lsu_busy), 32'h0);
    chk("rst_load_valid", 32'(load_valid), 32'h0);
    chk("rst_err", 32'(lsu_err), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    rst = 1'b0;

    // Aligned byte store and byte loads from the same lane.
    push_mem(1'b1, 10'd4, 4'b1000, 32'hAB000000);
    req(1'b0, 1'b1, BYTE, 1'b0, 32'h13, 32'hCDEF12AB, 1, "st_b_13");
    push_mem(1'b0, 10'd4, 4'b0000, 32'h0); exp_load.push_back(32'hFFFFFFAB);
    req(1'b1, 1'b0, BYTE, 1'b1, 32'h13, 32'h0, 2, "ld_bs_13");
    push_mem(1'b0, 10'd4, 4'b0000, 32'h0); exp_load.push_back(32'h000000AB);
    req(1'b1, 1'b0, BYTE, 1'b0, 32'h13, 32'h0, 2, "ld_bu_13");

    // Halfword loads from RAM[8] = 0x80017F00.
    push_mem(1'b1, 10'd8, 4'b1111, 32'h80017F00);
    req(1'b0, 1'b1, WORD, 1'b0, 32'h20, 32'h80017F00, 1, "st_w_20");
    push_mem(1'b0, 10'd8, 4'b0000, 32'h0); exp_load.push_back(32'h00008001);
    req(1'b1, 1'b0, HALF, 1'b0, 32'h22, 32'h0, 2, "ld_hu_22");
    push_mem(1'b0, 10'd8, 4'b0000, 32'h0); exp_load.push_back(32'hFFFF8001);
    req(1'b1, 1'b0, HALF, 1'b1, 32'h22, 32'h0, 2, "ld_hs_22");

    // Misaligned word store/load at 0x07.
    push_mem(1'b1, 10'd1, 4'b1000, 32'h44000000);
    push_mem(1'b1, 10'd2, 4'b0111, 32'h00112233);
    req(1'b0, 1'b1, WORD, 1'b0, 32'h07, 32'h11223344, 2, "st_w_07");
    push_mem(1'b0, 10'd1, 4'b0000, 32'h0); push_mem(1'b0, 10'd2, 4'b0000, 32'h0);
    exp_load.push_back(32'h11223344);
    req(1'b1, 1'b0, WORD, 1'b1, 32'h07, 32'h0, 3, "ld_w_07");

    // Misaligned halfword store/load at 0x0B.
    push_mem(1'b1, 10'd2, 4'b1000, 32'hEF000000);
    push_mem(1'b1, 10'd3, 4'b0001, 32'h001234BE);
    req(1'b0, 1'b1, HALF, 1'b0, 32'h0B, 32'h1234BEEF, 2, "st_h_0b");
    push_mem(1'b0, 10'd2, 4'b0000, 32'h0); push_mem(1'b0, 10'd3, 4'b0000, 32'h0);
    exp_load.push_back(32'hFFFFBEEF);
    req(1'b1, 1'b0, HALF, 1'b1, 32'h0B, 32'h0, 3, "ld_hs_0b");

    // Word at top of RAM with o=2 wraps the second access to word 0.
    push_mem(1'b1, 10'h3FF, 4'b1100, 32'hF00D0000);
    push_mem(1'b1, 10'h000, 4'b0011, 32'h0000CAFE);
    req(1'b0, 1'b1, WORD, 1'b0, 32'h00000FFE, 32'hCAFEF00D, 2, "st_w_ffe");
    push_mem(1'b0, 10'h3FF, 4'b0000, 32'h0); push_mem(1'b0, 10'h000, 4'b0000, 32'h0);
    exp_load.push_back(32'hCAFEF00D);
    req(1'b1, 1'b0, WORD, 1'b0, 32'h00000FFE, 32'h0, 3, "ld_w_ffe");

    // Rejected requests on the splitting instance.
    exp_err_n++;
    req(1'b1, 1'b0, 4'b0101, 1'b0, 32'h10, 32'h0, 0, "bad_type");
    chk("load_data_held", load_data, 32'hCAFEF00D);
    exp_err_n++;
    req(1'b1, 1'b1, WORD, 1'b0, 32'h10, 32'h0, 0, "rd_and_wr");

    // Instance without splitting rejects misaligned and illegal requests.
    exp_err0_n++;
    @(negedge clk); d0_rd = 1'b1; d0_typ = WORD; d0_addr = 32'h07;
    @(posedge clk); #1;
    chk("d0_mis_word_err", 32'(d0_err), 32'h1);
    chk("d0_mis_word_busy", 32'(d0_busy), 32'h0);
    d0_rd = 1'b0;
    exp_err0_n++;
    @(negedge clk); d0_wr = 1'b1; d0_typ = HALF; d0_addr = 32'h03;
    @(posedge clk); #1;
    chk("d0_mis_half_busy", 32'(d0_busy), 32'h0);
    d0_wr = 1'b0;
    exp_err0_n++;
    @(negedge clk); d0_rd = 1'b1; d0_typ = 4'b0101; d0_addr = 32'h10;
    @(posedge clk); #1;
    chk("d0_bad_type_busy", 32'(d0_busy), 32'h0);
    d0_rd = 1'b0;

    // Reset in the cycle after a misaligned load accept.
    push_mem(1'b0, 10'd1, 4'b0000, 32'h0);
    @(negedge clk); rd = 1'b1; typ = WORD; sgn = 1'b0; addr = 32'h07;
    @(posedge clk); #1;
    chk("rstmid_accept_busy", 32'(lsu_busy), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_busy", 32'(lsu_busy), 32'h0);
    chk("rstmid_mem_en", 32'(mem_en), 32'h0);
    chk("rstmid_load_valid", 32'(load_valid), 32'h0);
    chk("rstmid_load_data", load_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; typ = BYTE; addr = 32'h13;
    push_mem(1'b0, 10'd4, 4'b0000, 32'h0); exp_load.push_back(32'h000000AB);
    @(posedge clk); #1;
    chk("rstmid_new_accept", 32'(lsu_busy), 32'h1);
    cnt = 1;
    while (lsu_busy && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("rstmid_new_busy_cycles", 32'(cnt - 1), 32'h2);
    rd = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mem_accesses_missing", 32'(exp_mem.size()), 32'h0);
    chk("loads_missing", 32'(exp_load.size()), 32'h0);
    chk("errs_missing", 32'(exp_err_n), 32'h0);
    chk("d0_errs_missing", 32'(exp_err0_n), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
